muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_if.sv | 29 ++
 rtl/muldiv_addsub.sv | 17 +
 rtl/muldiv_unit.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, iteration count.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam int MULDIV_ITER = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Magnitude of a two's-complement operand; unsigned ops pass straight through.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage request/result bundle between the pipeline and the multiply/divide unit.
// Latency: n/a (wires only).
// Backpressure: the master must hold off start while busy is high.
interface muldiv_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              hi_we;
    logic              lo_we;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              div_by_zero;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_addsub.sv
// 33-bit adder/subtractor shared by the multiply accumulate and the divide trial subtract.
// Latency: combinational.
// Backpressure: none.
module muldiv_addsub (
    input  logic [32:0] x,
    input  logic [32:0] y,
    input  logic        sub,
    output logic [32:0] sum,
    output logic        cout
);
    logic [33:0] full;

    // Subtract is x + ~y + 1; carry-out high means no borrow (x >= y).
    assign full = {1'b0, x} + {1'b0, y ^ {33{sub}}} + {33'd0, sub};
    assign sum  = full[32:0];
    assign cout = full[33];
endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide engine for mult/multu/div/divu owning HI/LO; divide hardware only with MULDIV_DIV_EN.
// Latency: 33 cycles start edge to done; divide-by-zero (or divide when compiled out) finishes in 1.
// Backpressure: none; start is dropped unless idle, the pipeline stalls on busy.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave bus
);

    localparam logic [4:0] LAST_ITER = 5'(MULDIV_ITER - 1);

    state_t              state;
    logic [4:0]          cnt;
    logic [DATA_W-1:0]   mcand;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] prod_nxt;
    logic [2*DATA_W-1:0] prod_neg;
    logic                neg_lo;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic [DATA_W-1:0]   fix_hi;
    logic [DATA_W-1:0]   fix_lo;
    logic                done_q;
    logic                dbz_out;
    logic                sgn_op;

    logic [32:0]         as_x;
    logic [32:0]         as_y;
    logic [32:0]         as_sum;
    logic                as_sub;
    logic                as_cout;

`ifdef MULDIV_DIV_EN
    logic                is_div;
    logic                neg_hi;
    logic                dbz_q;
    logic [32:0]         div_shift;
`else
    logic                skip_wr;
    wire                 unused_cout = as_cout;
`endif

    assign sgn_op = ~bus.op[0];

    muldiv_addsub u_addsub (
        .x    (as_x),
        .y    (as_y),
        .sub  (as_sub),
        .sum  (as_sum),
        .cout (as_cout)
    );

    // Operand steering into the single add/sub: multiply adds the multiplicand when the
    // product LSB is set, divide always trial-subtracts the divisor from the shifted remainder.
    always_comb begin
`ifdef MULDIV_DIV_EN
        div_shift = {prod[63:32], prod[31]};
        as_sub    = is_div;
        as_x      = is_div ? div_shift : {1'b0, prod[63:32]};
        as_y      = {1'b0, (is_div || prod[0]) ? mcand : 32'd0};
`else
        as_sub    = 1'b0;
        as_x      = {1'b0, prod[63:32]};
        as_y      = {1'b0, prod[0] ? mcand : 32'd0};
`endif
    end

    always_comb begin
        prod_nxt = {as_sum, prod[31:1]};
`ifdef MULDIV_DIV_EN
        // A remainder needing bit 32 always exceeds the divisor, so 32 bits suffice on restore.
        if (is_div) begin
            if (as_cout) prod_nxt = {as_sum[31:0], prod[30:0], 1'b1};
            else         prod_nxt = {div_shift[31:0], prod[30:0], 1'b0};
        end
`endif
    end

    always_comb begin
        prod_neg = ~prod + 64'd1;
        fix_hi   = prod[63:32];
        fix_lo   = prod[31:0];
`ifdef MULDIV_DIV_EN
        if (is_div) begin
            if (neg_hi) fix_hi = ~prod[63:32] + 32'd1;
            if (neg_lo) fix_lo = ~prod[31:0] + 32'd1;
        end else if (neg_lo) begin
            {fix_hi, fix_lo} = prod_neg;
        end
`else
        if (neg_lo) {fix_hi, fix_lo} = prod_neg;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mcand   <= '0;
            prod    <= '0;
            neg_lo  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_out <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div  <= 1'b0;
            neg_hi  <= 1'b0;
            dbz_q   <= 1'b0;
`else
            skip_wr <= 1'b0;
`endif
        end else begin
            done_q  <= 1'b0;
            dbz_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hi_we) hi_q <= bus.wdata;
                    if (bus.lo_we) lo_q <= bus.wdata;
                    if (bus.start) begin
                        cnt    <= '0;
                        neg_lo <= sgn_op & (bus.a[31] ^ bus.b[31]);
                        prod   <= {32'd0, abs32(bus.b, sgn_op)};
                        mcand  <= abs32(bus.a, sgn_op);
                        state  <= CALC;
`ifdef MULDIV_DIV_EN
                        is_div <= bus.op[1];
                        neg_hi <= sgn_op & bus.a[31];
                        dbz_q  <= 1'b0;
                        if (bus.op[1]) begin
                            prod  <= {32'd0, abs32(bus.a, sgn_op)};
                            mcand <= abs32(bus.b, sgn_op);
                            if (bus.b == '0) begin
                                // Pre-load the architectural divide-by-zero result; FIX copies it out.
                                prod   <= {bus.a, 32'hFFFF_FFFF};
                                neg_lo <= 1'b0;
                                neg_hi <= 1'b0;
                                dbz_q  <= 1'b1;
                                state  <= FIX;
                            end
                        end
`else
                        skip_wr <= bus.op[1];
                        if (bus.op[1]) state <= FIX;
`endif
                    end
                end
                CALC: begin
                    prod <= prod_nxt;
                    cnt  <= cnt + 5'd1;
                    if (cnt == LAST_ITER) state <= FIX;
                end
                FIX: begin
                    state  <= IDLE;
                    done_q <= 1'b1;
`ifdef MULDIV_DIV_EN
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    dbz_out <= dbz_q;
`else
                    if (!skip_wr) begin
                        hi_q <= fix_hi;
                        lo_q <= fix_lo;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_out;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus hand sequences for busy/reset/back-to-back cases.
// Divide expectations follow whether MULDIV_DIV_EN is defined for the build.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    localparam int          NV     = 13;
    localparam logic [31:0] PRE_HI = 32'h1357_9BDF;
    localparam logic [31:0] PRE_LO = 32'h2468_ACE0;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_chk  = 0;
    vec_t vecs [NV];

    muldiv_if #(.DATA_W(32)) bus ();

    muldiv_unit #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Called just after a falling edge; returns just after the falling edge following the accept edge.
    task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = ~op;
        bus.a     = ~a;
        bus.b     = 32'h0;
    endtask

    task automatic wait_done(output int lat, output int busy_cyc, output bit ok);
        lat      = 0;
        busy_cyc = 0;
        ok       = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                ok  = 1'b1;
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic mt_write(input logic [31:0] h, input logic [31:0] l);
        bus.hi_we = 1'b1;
        bus.wdata = h;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b1;
        bus.wdata = l;
        @(negedge clk);
        bus.lo_we = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   lat;
        int   bc;
        bit   ok;

        vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
        vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33};
        vecs[2]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33};
        vecs[3]  = '{OP_MULTU, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A, 1'b0, 33};
        vecs[4]  = '{OP_MULT,  32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0, 33};
        vecs[5]  = '{OP_MULT,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 33};
        vecs[6]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[7]  = '{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 33};
        vecs[8]  = '{OP_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1};
        vecs[9]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33};
        vecs[10] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[11] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, 1'b0, 33};
        vecs[12] = '{OP_DIV,   32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1};

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'h0;
        bus.b     = 32'h0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = 32'h0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hi",   bus.hi, 32'h0);
        chk("rst_lo",   bus.lo, 32'h0);
        chk("rst_busy", {31'd0, bus.busy}, 32'h0);
        chk("rst_done", {31'd0, bus.done}, 32'h0);
        chk("rst_dbz",  {31'd0, bus.div_by_zero}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
`ifndef MULDIV_DIV_EN
            if (v.op[1]) begin
                v.hi  = PRE_HI;
                v.lo  = PRE_LO;
                v.dbz = 1'b0;
                v.lat = 1;
            end
`endif
            mt_write(PRE_HI, PRE_LO);
            chk($sformatf("v%0d_mthi", i), bus.hi, PRE_HI);
            chk($sformatf("v%0d_mtlo", i), bus.lo, PRE_LO);
            drive_start(v.op, v.a, v.b);
            wait_done(lat, bc, ok);
            chk($sformatf("v%0d_timeout", i), {31'd0, ok}, 32'h1);
            chk($sformatf("v%0d_hi", i), bus.hi, v.hi);
            chk($sformatf("v%0d_lo", i), bus.lo, v.lo);
            chk($sformatf("v%0d_dbz", i), {31'd0, bus.div_by_zero}, {31'd0, v.dbz});
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v.lat));
            chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(v.lat));
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), {31'd0, bus.done}, 32'h0);
            chk($sformatf("v%0d_dbz_pulse", i), {31'd0, bus.div_by_zero}, 32'h0);
        end

        // start and MTHI/MTLO while busy are dropped; no queued operation follows
        mt_write(PRE_HI, PRE_LO);
        drive_start(OP_MULTU, 32'd6, 32'd7);
        repeat (8) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'h2;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        chk("busy_mthi_ignored", bus.hi, PRE_HI);
        chk("busy_mtlo_ignored", bus.lo, PRE_LO);
        wait_done(lat, bc, ok);
        chk("busy_timeout", {31'd0, ok}, 32'h1);
        chk("busy_latency", 32'(lat), 32'd24);
        chk("busy_hi", bus.hi, 32'h0);
        chk("busy_lo", bus.lo, 32'd42);
        repeat (3) @(negedge clk);
        chk("busy_no_queue", {31'd0, bus.busy}, 32'h0);
        chk("busy_no_done",  {31'd0, bus.done}, 32'h0);

        // back-to-back: second start is driven in the done cycle
        drive_start(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bc, ok);
        chk("b2b_first_lo", bus.lo, 32'h0000_0001);
        chk("b2b_first_hi", bus.hi, 32'hFFFF_FFFE);
        drive_start(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
        chk("b2b_accepted", {31'd0, bus.busy}, 32'h1);
        wait_done(lat, bc, ok);
        chk("b2b_timeout", {31'd0, ok}, 32'h1);
        chk("b2b_latency", 32'(lat), 32'd33);
        chk("b2b_hi", bus.hi, 32'hFFFF_FFFF);
        chk("b2b_lo", bus.lo, 32'hFFFF_FFF1);

        // reset during iteration 10 aborts and clears everything
        @(negedge clk);
        mt_write(PRE_HI, PRE_LO);
        drive_start(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_hi",   bus.hi, 32'h0);
        chk("abort_lo",   bus.lo, 32'h0);
        chk("abort_busy", {31'd0, bus.busy}, 32'h0);
        chk("abort_done", {31'd0, bus.done}, 32'h0);
        chk("abort_dbz",  {31'd0, bus.div_by_zero}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // MTHI in the start cycle lands first, then the result overwrites it
        bus.hi_we = 1'b1;
        bus.wdata = 32'hCAFE_F00D;
        drive_start(OP_MULTU, 32'd6, 32'd7);
        bus.hi_we = 1'b0;
        chk("same_cycle_mthi", bus.hi, 32'hCAFE_F00D);
        chk("same_cycle_busy", {31'd0, bus.busy}, 32'h1);
        wait_done(lat, bc, ok);
        chk("fresh_timeout", {31'd0, ok}, 32'h1);
        chk("fresh_latency", 32'(lat), 32'd33);
        chk("fresh_hi", bus.hi, 32'h0);
        chk("fresh_lo", bus.lo, 32'd42);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
